// File: rtl/zap_dump_pkg.sv
// rtl/zap_dump_pkg.sv - shared types and default sizes for the register file dump engine
package zap_dump_pkg;

  localparam int NUM_REGS_DEF = 40;
  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dump_state_e;

endpackage

// File: rtl/zap_dump_out_stage.sv
// rtl/zap_dump_out_stage.sv - single-entry valid/ready holding register for data and index
module zap_dump_out_stage
  import zap_dump_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic              i_accept,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr
);

  // Flush beats load, load beats a plain accept; payload only moves on load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_addr  <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
      o_addr  <= i_addr;
    end else if (i_accept) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/zap_regfile_dump.sv
// rtl/zap_regfile_dump.sv - streams an inclusive register file range over valid/ready; ZAP_REGFILE_DUMP_XSUM_EN adds an XOR checksum
module zap_regfile_dump
  import zap_dump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_first,
  input  logic [ADDR_W-1:0] i_last,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [DATA_W-1:0] o_xsum
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_e       state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_q;

  logic bad_req;
  logic start_ok;
  logic loadable;
  logic accept;
  logic load;
  logic flush;

  assign bad_req  = (i_first > i_last) || (i_last > LAST_IDX);
  assign start_ok = (state == ST_IDLE) && i_start && !bad_req;
  assign loadable = !o_valid || i_ready;
  assign accept   = o_valid && i_ready;
  assign flush    = (state != ST_IDLE) && i_abort;
  assign load     = (state == ST_RUN) && loadable && !i_abort;

  assign o_rd_addr = ptr;

  zap_dump_out_stage #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (load),
    .i_accept  (accept),
    .i_flush   (flush),
    .i_data    (i_rd_data),
    .i_addr    (ptr),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_addr    (o_addr)
  );

  // Sequencer: range check, pointer walk, and the busy/done/err flags.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      last_q <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (bad_req) begin
              o_err <= 1'b1;
            end else begin
              ptr    <= i_first;
              last_q <= i_last;
              state  <= ST_RUN;
              o_busy <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (loadable) begin
            // last_q < NUM_REGS <= 2^ADDR_W, so the increment cannot wrap
            if (ptr == last_q) begin
              state <= ST_DRAIN;
            end else begin
              ptr <= ptr + ADDR_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (accept) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef ZAP_REGFILE_DUMP_XSUM_EN
  logic [DATA_W-1:0] xsum_q;

  // Checksum restarts on an accepted request and folds in every delivered beat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      xsum_q <= '0;
    end else if (start_ok) begin
      xsum_q <= '0;
    end else if (accept) begin
      xsum_q <= xsum_q ^ o_data;
    end
  end

  assign o_xsum = xsum_q;
`else
  assign o_xsum = '0;
`endif

endmodule

// File: tb/tb_zap_regfile_dump.sv
// tb/tb_zap_regfile_dump.sv - self-checking bench for zap_regfile_dump
module tb_zap_regfile_dump;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_start;
  logic [5:0]  i_first;
  logic [5:0]  i_last;
  logic        i_abort;
  logic [5:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data;
  logic [5:0]  o_addr;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_xsum;

  logic [31:0] mem [0:63];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  first;
    logic [5:0]  last;
    bit          exp_err;
    int          exp_n;
    int          exp_done;
    logic [31:0] exp_xsum;
  } vec_t;

  vec_t vecs [6];

  always #5 i_clk = ~i_clk;

  assign i_rd_data = mem[o_rd_addr];

  zap_regfile_dump dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_start   (i_start),
    .i_first   (i_first),
    .i_last    (i_last),
    .i_abort   (i_abort),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (i_rd_data),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_addr    (o_addr),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_xsum    (o_xsum)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xs_expect(input logic [31:0] v);
`ifdef ZAP_REGFILE_DUMP_XSUM_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rd_addr"}, 32'(o_rd_addr), 0);
    chk({tag, " valid"}, 32'(o_valid), 0);
    chk({tag, " data"}, o_data, 0);
    chk({tag, " addr"}, 32'(o_addr), 0);
    chk({tag, " busy"}, 32'(o_busy), 0);
    chk({tag, " done"}, 32'(o_done), 0);
    chk({tag, " err"}, 32'(o_err), 0);
    chk({tag, " xsum"}, o_xsum, 0);
  endtask

  // Start at cycle 0 with ready held high; beats and flags are timed against cycle numbers.
  task automatic run_check(input vec_t v, input string tag);
    int nb, done_c, err_c, busy1;
    nb = 0; done_c = -1; err_c = 0; busy1 = 0;
    i_first = v.first; i_last = v.last; i_start = 1'b1; i_ready = 1'b1;
    step();
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 1) busy1 = int'(o_busy);
      if (o_err) err_c++;
      if (o_valid && i_ready) begin
        if (nb == 0) chk({tag, " first_beat_cycle"}, cyc, 2);
        chk({tag, " beat_addr"}, 32'(o_addr), 32'(v.first) + nb);
        chk({tag, " beat_data"}, o_data, mem[32'(v.first) + nb]);
        nb++;
      end
      if (o_done) begin
        done_c = cyc;
        break;
      end
      if (v.exp_err && cyc >= 6) break;
      step();
    end
    chk({tag, " err_pulses"}, err_c, v.exp_err ? 1 : 0);
    chk({tag, " busy_cycle1"}, busy1, v.exp_err ? 0 : 1);
    chk({tag, " beat_count"}, nb, v.exp_n);
    chk({tag, " done_cycle"}, done_c, v.exp_done);
    if (!v.exp_err) chk({tag, " xsum"}, o_xsum, xs_expect(v.exp_xsum));
    step();
  endtask

  initial begin
    int nb, done_c;
    logic hold_prev;
    logic [31:0] prev_d, model_xs;
    logic [5:0]  prev_a;

    for (int i = 0; i < 64; i++) mem[i] = 32'h11 * (i + 1);

    vecs[0] = '{6'd0,  6'd3,  1'b0, 4, 6, 32'h44};
    vecs[1] = '{6'd5,  6'd5,  1'b0, 1, 3, 32'h66};
    vecs[2] = '{6'd7,  6'd3,  1'b1, 0, -1, 32'h0};
    vecs[3] = '{6'd0,  6'd40, 1'b1, 0, -1, 32'h0};
    vecs[4] = '{6'd2,  6'd4,  1'b0, 3, 5, 32'h22};
    vecs[5] = '{6'd39, 6'd39, 1'b0, 1, 3, 32'h2A8};

    i_reset_n = 1'b0; i_start = 1'b0; i_first = '0; i_last = '0;
    i_abort = 1'b0; i_ready = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    i_reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_check(vecs[i], $sformatf("vec%0d", i));

    // Full range with ready alternating: order, no loss/duplication, stability under stall.
    nb = 0; done_c = -1; hold_prev = 1'b0; prev_d = '0; prev_a = '0; model_xs = '0;
    i_first = 6'd0; i_last = 6'd39; i_start = 1'b1; i_ready = 1'b1;
    step();
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      i_ready = (cyc % 2) == 1;
      if (hold_prev) begin
        chk("toggle stable_data", o_data, prev_d);
        chk("toggle stable_addr", 32'(o_addr), 32'(prev_a));
      end
      if (o_valid && i_ready) begin
        chk("toggle beat_addr", 32'(o_addr), nb);
        chk("toggle beat_data", o_data, mem[nb]);
        model_xs = model_xs ^ mem[nb];
        nb++;
      end
      hold_prev = o_valid && !i_ready;
      prev_d = o_data;
      prev_a = o_addr;
      if (o_done) begin
        done_c = cyc;
        break;
      end
      step();
    end
    chk("toggle beat_count", nb, 40);
    chk("toggle done_seen", 32'(done_c > 0), 1);
    chk("toggle xsum", o_xsum, xs_expect(model_xs));
    i_ready = 1'b1;
    step();

    // Abort in the cycle the third beat is accepted.
    nb = 0;
    i_first = 6'd0; i_last = 6'd9; i_start = 1'b1; i_ready = 1'b1;
    step();
    i_start = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (o_valid && i_ready) begin
        nb++;
        if (nb == 3) begin
          chk("abort third_beat_cycle", cyc, 4);
          i_abort = 1'b1;
          break;
        end
      end
      step();
    end
    step();
    i_abort = 1'b0;
    chk("abort delivered", nb, 3);
    chk("abort valid_after", 32'(o_valid), 0);
    chk("abort busy_after", 32'(o_busy), 0);
    for (int k = 0; k < 4; k++) begin
      chk("abort no_done", 32'(o_done), 0);
      chk("abort no_err", 32'(o_err), 0);
      chk("abort no_valid", 32'(o_valid), 0);
      step();
    end
    run_check('{6'd0, 6'd1, 1'b0, 2, 4, 32'h33}, "post_abort");

    // Asynchronous reset in the middle of a dump.
    i_first = 6'd0; i_last = 6'd9; i_start = 1'b1; i_ready = 1'b1;
    step();
    i_start = 1'b0;
    step();
    step();
    chk("midreset valid_before", 32'(o_valid), 1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    step();
    run_check('{6'd0, 6'd1, 1'b0, 2, 4, 32'h33}, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zap_regfile_dump.md
# zap_regfile_dump

Sequential read-out engine for the flip-flop register file: on request it walks an inclusive address range of the register file through one combinational read port and streams each word, tagged with its index, to a consumer over a valid/ready handshake. It sits between the core's register file (read port D, free when the core is halted) and the debug/trace unit, for state dumps and context save. It only reads; it never writes the register file.

## Interface
- NUM_REGS, 40, number of register file entries
- ADDR_W, 6, register index width
- DATA_W, 32, register word width

- i_clk  in  1  clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  request pulse, sampled only in IDLE
- i_first  in  ADDR_W  first index, inclusive, sampled with i_start
- i_last  in  ADDR_W  last index, inclusive, sampled with i_start
- i_abort  in  1  terminate the dump, sampled in RUN and DRAIN
- o_rd_addr  out  ADDR_W  register file read address
- i_rd_data  in  DATA_W  register file read data, combinational from o_rd_addr
- o_valid  out  1  output beat valid
- i_ready  in  1  consumer accepts beat
- o_data  out  DATA_W  register word
- o_addr  out  ADDR_W  index of o_data
- o_busy  out  1  high in RUN and DRAIN
- o_done  out  1  one-cycle pulse after the last beat is accepted
- o_err  out  1  one-cycle pulse on a rejected request
- o_xsum  out  DATA_W  XOR checksum; see Configuration

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE with i_start:
  - If i_first > i_last or i_last >= NUM_REGS: o_err pulses next cycle; the block stays in IDLE.
  - Otherwise: ptr <= i_first, end <= i_last, go to RUN.
- o_rd_addr = ptr in all states.
- The output holding register (o_data, o_addr, o_valid) is loadable when !o_valid or i_ready.
- RUN, when the holding register is loadable:
  - o_data <= i_rd_data; o_addr <= ptr; o_valid <= 1.
  - If ptr == end: go to DRAIN, ptr unchanged. Otherwise ptr <= ptr + 1.
  - The increment never wraps, because end < NUM_REGS <= 2^ADDR_W.
- DRAIN, when o_valid and i_ready: o_valid <= 0, go to IDLE, o_done pulses the following cycle.
- In RUN, an accept with no load (impossible while loadable) clears o_valid.
- Handshake:
  - o_data and o_addr are stable while o_valid and !i_ready.
  - o_valid never drops without an accept, except on abort or reset.
- i_abort in RUN or DRAIN: o_valid <= 0, go to IDLE, no o_done and no o_err.
  - Abort wins over a simultaneous accept and load. A beat accepted in the abort cycle counts as delivered.
- i_start while busy is ignored.
- Each word is sampled in the cycle it is loaded. The dump is not an atomic snapshot: register file writes before a word's load cycle are visible, later ones are not.

## Timing
- Reset values: o_rd_addr=0, o_valid=0, o_data=0, o_addr=0, o_busy=0, o_done=0, o_err=0, o_xsum=0; state IDLE, ptr=0.
- Request at cycle 0:
  - RUN and o_busy in cycle 1.
  - First o_valid in cycle 2.
- With i_ready held high: one beat per cycle. For a range of N words, beats occupy cycles 2..N+1 and o_done is in cycle N+2.
- Each ready-low cycle stalls the stream by exactly one cycle. No beat is lost or duplicated.
- Reset asserted mid-dump: all outputs return to their reset values immediately (asynchronously). There is no resume.

## Configuration
- ZAP_REGFILE_DUMP_XSUM_EN defined:
  - An accumulator clears on an accepted start and XORs o_data on every accepted beat.
  - o_xsum holds the final value from the o_done cycle until the next accepted start.
- Not defined: o_xsum is constant 0 and no accumulator logic is built.

## Structure
- Package zap_dump_pkg: state enum (IDLE, RUN, DRAIN), and the NUM_REGS, ADDR_W and DATA_W defaults.
- Sub-module zap_dump_out_stage: a single-entry valid/ready holding register carrying data and addr, with load, accept and flush inputs. The FSM, pointer and checksum stay in the top level.

## Test plan
- Range 0..3 holding 0x11, 0x22, 0x33, 0x44, i_ready=1, start at cycle 0:
  - Beats (0,0x11)..(3,0x44) in cycles 2..5.
  - o_done in cycle 6.
  - o_xsum=0x44 when XSUM_EN is defined.
- Range 5..5: one beat (5, mem[5]) in cycle 2, o_done in cycle 3.
- Range 0..39 with i_ready toggling 1,0,1,0:
  - All 40 beats arrive in index order, none dropped or duplicated.
  - o_data and o_addr are stable whenever valid is held through a not-ready cycle.
- i_first=7, i_last=3, then i_first=0, i_last=40:
  - o_err pulses once for each request.
  - o_busy stays 0 and no beats are produced.
- i_abort in the cycle of the third beat's accept on range 0..9:
  - Three beats are delivered, then o_valid=0 and IDLE next cycle.
  - No o_done.
  - A new start is accepted normally.
- i_reset_n dropped mid-dump between clock edges: all outputs are zero immediately. After release, a fresh 0..1 dump completes correctly.
